sum_window_accumulator: RTL and testbench

- Downstream stage of the 8-bit adder datapath: consumes the stream of 8-bit sums and accumulates them over a programmable window of N samples.
- Emits each window total on a valid/ready output port, together with an overflow flag.
- Lets the top level report averaged or integrated sums instead of raw per-cycle values.

---
 rtl/sum_window_accumulator.sv | 128 ++++++++++++
 tb/tb_sum_window_accumulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sum_window_accumulator.sv
// sum_window_accumulator
//   Accumulates a stream of 8-bit sums over a window of N samples and
//   presents each window total on a valid/ready port with an overflow flag.
//   The window length is sampled with the first sample of each window.
//
// Parameters
//   ACC_W : accumulator / result width (9..24)
//   CNT_W : window-length field width; window of 2^CNT_W when win_len == 0
//   SAT   : 1 = saturate at 2^ACC_W-1 on overflow, 0 = wrap
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   clear               flush partial window or pending result
//   win_len             window length (0 => 2^CNT_W)
//   in_data/valid/ready sample input handshake
//   out_data/ovf/valid  window total, overflow flag, valid
//   out_ready           consumer accepts the result
module sum_window_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 4,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] win_len,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W:0]   len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [CNT_W:0]   win_eff;   // decoded win_len (0 -> 2^CNT_W)
    logic [CNT_W:0]   len_cur;   // length governing the current window
    logic [CNT_W:0]   cnt_inc;
    logic [ACC_W:0]   sum;       // one extra bit to catch the carry-out

    always_comb begin
        win_eff = (win_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, win_len};
        // On the first sample the latched length is not yet loaded, so the
        // freshly decoded value decides whether a 1-sample window closes.
        len_cur = (cnt_q == '0) ? win_eff : len_q;
        cnt_inc = cnt_q + 1'b1;
        sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, in_data};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Drops any sample offered this cycle and discards a pending result.
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == '0)
                            len_d = win_eff;
                        if (sum[ACC_W]) begin
                            ovf_d = 1'b1;
                            // A saturated acc re-saturates on every nonzero add,
                            // so it stays pinned for the rest of the window.
                            acc_d = SAT ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_cur)
                            state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come from registered state only (plus rst_n gating in_ready).
    assign in_ready  = rst_n && (state_q == ACCUM);
    assign out_valid = (state_q == EMIT);
    assign out_data  = (state_q == EMIT) ? acc_q : '0;
    assign out_ovf   = (state_q == EMIT) ? ovf_q : 1'b0;

endmodule

// File: tb/tb_sum_window_accumulator.sv
module tb_sum_window_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [3:0] win_len;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic        in_ready,  s9_in_ready,  w9_in_ready;
    logic [15:0] out_data;
    logic [8:0]  s9_out_data, w9_out_data;
    logic        out_ovf,   s9_out_ovf,   w9_out_ovf;
    logic        out_valid, s9_out_valid, w9_out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sum_window_accumulator #(.ACC_W(16), .CNT_W(4), .SAT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .win_len(win_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    sum_window_accumulator #(.ACC_W(9), .CNT_W(4), .SAT(1'b1)) dut_s9 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .win_len(win_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(s9_in_ready),
        .out_data(s9_out_data), .out_ovf(s9_out_ovf), .out_valid(s9_out_valid),
        .out_ready(out_ready)
    );

    sum_window_accumulator #(.ACC_W(9), .CNT_W(4), .SAT(1'b0)) dut_w9 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .win_len(win_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(w9_in_ready),
        .out_data(w9_out_data), .out_ovf(w9_out_ovf), .out_valid(w9_out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time
    // unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; win_len = 4'd0; in_data = 8'd0;
        in_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_in_ready",  32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);
        chk("rst_out_ovf",   32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic window: 10+20+30+40
        win_len = 4'd4; out_ready = 1'b1;
        send(8'd10); send(8'd20); send(8'd30);
        chk("basic_in_ready_mid", 32'(in_ready), 32'd1);
        chk("basic_accum_data0",  32'(out_data), 32'd0);
        send(8'd40);
        in_valid = 1'b0;
        chk("basic_valid",    32'(out_valid), 32'd1);
        chk("basic_data",     32'(out_data), 32'd100);
        chk("basic_ovf",      32'(out_ovf), 32'd0);
        chk("basic_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("basic_valid_drop", 32'(out_valid), 32'd0);
        chk("basic_ready_back", 32'(in_ready), 32'd1);

        // Window of 16 with back-pressure
        win_len = 4'd0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'hFF);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data), 32'd4080);
            if (i == 5) out_ready = 1'b1;
            step();
        end
        chk("bp_released", 32'(out_valid), 32'd0);
        win_len = 4'd1;
        send(8'd7);
        in_valid = 1'b0;
        chk("bp_new_window", 32'(out_data), 32'd7);
        step();

        // Saturation / wrap: 200*3 = 600
        win_len = 4'd3;
        send(8'd200); send(8'd200); send(8'd200);
        in_valid = 1'b0;
        chk("sat16_data", 32'(out_data), 32'd600);
        chk("sat16_ovf",  32'(out_ovf), 32'd0);
        chk("sat9_valid", 32'(s9_out_valid), 32'd1);
        chk("sat9_data",  32'(s9_out_data), 32'd511);
        chk("sat9_ovf",   32'(s9_out_ovf), 32'd1);
        chk("wrap9_data", 32'(w9_out_data), 32'd88);
        chk("wrap9_ovf",  32'(w9_out_ovf), 32'd1);
        step();
        chk("sat_ovf_cleared", 32'(s9_out_ovf), 32'd0);

        // Clear mid-window; the sample offered with clear is dropped
        win_len = 4'd4;
        send(8'd50); send(8'd60);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd77;
        chk("clr_in_ready_high", 32'(in_ready), 32'd1);
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        in_valid = 1'b0;
        chk("clr_mid_valid", 32'(out_valid), 32'd1);
        chk("clr_mid_data",  32'(out_data), 32'd10);
        // Clear during EMIT beats out_ready
        clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_emit_valid", 32'(out_valid), 32'd0);
        chk("clr_emit_data",  32'(out_data), 32'd0);
        step();
        chk("clr_emit_stay", 32'(out_valid), 32'd0);

        // Latched length: 2 at first sample, then 5
        win_len = 4'd2;
        send(8'd5);
        win_len = 4'd5;
        send(8'd6);
        in_valid = 1'b0;
        chk("latch_valid", 32'(out_valid), 32'd1);
        chk("latch_data",  32'(out_data), 32'd11);
        step();

        // Reset mid-window
        win_len = 4'd4;
        send(8'd5); send(8'd5); send(8'd5);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data",  32'(out_data), 32'd0);
        chk("mrst_ovf",   32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        send(8'd5); send(8'd5); send(8'd5);
        chk("mrst_not_early", 32'(out_valid), 32'd0);
        send(8'd5);
        in_valid = 1'b0;
        chk("mrst_valid_after", 32'(out_valid), 32'd1);
        chk("mrst_data_after",  32'(out_data), 32'd20);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
